hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_COUNT, default 32, number of architectural registers; x0 is hard-wired zero.
REQ-002 Parameter REG_ADDR_W, default $clog2(REG_COUNT), width of register addresses.
REQ-003 Parameter LONG_LAT, default 4, range 2..15, execution cycles of the long-latency (mul/div) unit.
REQ-004 Parameter PERF_W, default 32, width of the stall performance counter.
REQ-005 clk  in  1  single clock, rising edge; one clock; reset is synchronous and active-low.
REQ-006 reset_n  in  1  synchronous active-low reset.
REQ-007 d_rs1, d_rs2, d_rd  in  REG_ADDR_W each  ID-stage register fields.
REQ-008 d_use_rs1, d_use_rs2, d_reg_we  in  1 each  ID instruction reads rs1 / reads rs2 / writes rd.
REQ-009 d_long_issue  in  1  ID instruction is a long-latency op.
REQ-010 e_b_taken  in  1  branch/jump taken in EX.
REQ-011 e_rs1, e_rs2  in  REG_ADDR_W each  EX-stage source fields.
REQ-012 m_rd, m_reg_we, m_is_load  in  REG_ADDR_W/1/1  DM-stage destination, write enable, load flag.
REQ-013 w_rd, w_reg_we  in  REG_ADDR_W/1  WB-stage destination and write enable.
REQ-014 forward_rrd1, forward_rrd2  out  2 each  forwarding select: NO / DM / WB (package enum).
REQ-015 stall_f, stall_if_id, flush_if_id, flush_id_ex  out  1 each  pipeline control.
REQ-016 lu_start, lu_wb_valid  out  1 each  start pulse to long unit; one-cycle result-writeback strobe.
REQ-017 lu_wb_rd  out  REG_ADDR_W  destination of the completing long op.
REQ-018 pending  out  REG_COUNT  scoreboard vector; bit i set = register i awaits a long result.
REQ-019 stall_cycles  out  PERF_W  saturating count of cycles with stall asserted.

Function
REQ-020 src1_hit = d_use_rs1 && d_rs1!=0; src2_hit likewise; comparisons with x0 never cause stalls or forwarding.
REQ-021 load_use = m_is_load && m_reg_we && m_rd!=0 && ((src1_hit && d_rs1==m_rd) || (src2_hit && d_rs2==m_rd)).
REQ-022 raw = (src1_hit && pending[d_rs1]) || (src2_hit && pending[d_rs2]); waw = d_reg_we && d_rd!=0 && pending[d_rd].
REQ-023 struct = d_long_issue && state!=IDLE; stall = load_use || raw || waw || struct, combinational.
REQ-024 stall_f = stall_if_id = stall; flush_if_id = e_b_taken; flush_id_ex = e_b_taken || stall.
REQ-025 issue = d_long_issue && !stall && !e_b_taken; lu_start = issue, combinational, same cycle.
REQ-026 FSM IDLE -> BUSY on issue: capture d_rd into tag, load counter with LONG_LAT-1, set pending[d_rd] when d_rd!=0.
REQ-027 BUSY: counter decrements each cycle; at counter==0 -> DONE.
REQ-028 DONE: lu_wb_valid=1, lu_wb_rd=tag for exactly one cycle, pending[tag] cleared at the clock edge ending DONE; next state IDLE.
REQ-029 Issue-to-lu_wb_valid latency = LONG_LAT cycles; no new issue accepted before IDLE (struct stall covers BUSY and DONE).
REQ-030 A dependent ID instruction stalls through the DONE cycle and proceeds in the cycle after.
REQ-031 e_b_taken does not cancel an op already in BUSY/DONE; it suppresses a same-cycle issue.
REQ-032 forward_rrd1 = DM if e_rs1!=0 && m_reg_we && m_rd==e_rs1; else WB if e_rs1!=0 && w_reg_we && w_rd==e_rs1; else NO. rrd2 identical on e_rs2. DM has priority.
REQ-033 stall_cycles increments on each cycle with stall=1; holds at all-ones.

Reset
REQ-034 With reset_n=0 at a clock edge: state=IDLE, counter=0, tag=0, pending=0, stall_cycles=0; lu_wb_valid=0 and lu_start=0 (start gated by reset) thereafter until release.
REQ-035 Reset mid-operation abandons the long op: no lu_wb_valid is produced for it.

Structure
REQ-036 Forwarding-select enum, FSM state enum and LONG_LAT limits live in the shared defines/package; no local duplicates.
REQ-037 One sub-module, lu_tracker (FSM, counter, tag, pending vector); hazard logic, forwarding and perf counter stay in the top.

Verification
REQ-038 Load to x5 in DM, ID add reads x5 -> stall=1, flush_id_ex=1, flush_if_id=0 for one cycle; stall_cycles=1.
REQ-039 LONG_LAT=4 div to x7 issued cycle 0 -> lu_start at 0, pending[7]=1 cycles 1-4, lu_wb_valid with lu_wb_rd=7 at cycle 4; dependent add stalls cycles 1-4, proceeds cycle 5.
REQ-040 Second long op at ID while BUSY -> stall until cycle after DONE, then lu_start=1.
REQ-041 e_rs1=3, m_rd=3 m_reg_we=1, w_rd=3 w_reg_we=1 -> forward_rrd1=DM; m_reg_we=0 -> WB; e_rs1=0 -> NO.
REQ-042 e_b_taken with d_long_issue same cycle -> lu_start=0, pending unchanged, flush_if_id=flush_id_ex=1.
REQ-043 reset_n low at cycle 2 of BUSY -> pending=0, state IDLE, no lu_wb_valid afterwards.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg
//   Shared types and limits for the hazard scoreboard and its long-latency
//   unit tracker: forwarding-select encoding, tracker FSM states, and the
//   supported latency range of the long (mul/div) unit.
package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        FWD_NO = 2'd0,
        FWD_DM = 2'd1,
        FWD_WB = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        LU_IDLE = 2'd0,
        LU_BUSY = 2'd1,
        LU_DONE = 2'd2
    } lu_state_e;

    localparam int LONG_LAT_MIN = 2;
    localparam int LONG_LAT_MAX = 15;
    localparam int LU_CNT_W     = $clog2(LONG_LAT_MAX + 1);

endpackage

// File: rtl/hazard_scoreboard_lu.sv
// lu_tracker
//   Tracks the single in-flight long-latency operation: FSM, cycle counter,
//   destination tag and the per-register pending vector.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   LU_IDLE | no op in flight; an issue pulse starts one
//   LU_BUSY | op executing; counter steps down toward zero
//   LU_DONE | result cycle: wb_valid high, pending[tag] cleared at exit
//
// Ports
//   clk, reset_n  clock, synchronous active-low reset
//   issue_i       start a long op this cycle (already qualified by caller)
//   issue_rd_i    destination register of the issuing op
//   busy_o        tracker not idle (structural hazard for a new long op)
//   pending_o     bit i set = register i awaits the long result
//   wb_valid_o    one-cycle writeback strobe
//   wb_rd_o       destination of the completing op
module lu_tracker
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_COUNT  = 32,
    parameter int REG_ADDR_W = $clog2(REG_COUNT),
    parameter int LONG_LAT   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  issue_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    output logic                  busy_o,
    output logic [REG_COUNT-1:0]  pending_o,
    output logic                  wb_valid_o,
    output logic [REG_ADDR_W-1:0] wb_rd_o
);

    // Out-of-range latencies are pulled into the supported window.
    localparam int LU_LAT = (LONG_LAT < LONG_LAT_MIN) ? LONG_LAT_MIN :
                            (LONG_LAT > LONG_LAT_MAX) ? LONG_LAT_MAX : LONG_LAT;
    localparam logic [LU_CNT_W-1:0] CNT_LOAD = LU_CNT_W'(LU_LAT - 1);

    lu_state_e             state_q, state_d;
    logic [LU_CNT_W-1:0]   cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0] tag_q, tag_d;
    logic [REG_COUNT-1:0]  pend_q, pend_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        pend_d  = pend_q;
        case (state_q)
            LU_IDLE: begin
                if (issue_i) begin
                    state_d = LU_BUSY;
                    cnt_d   = CNT_LOAD;
                    tag_d   = issue_rd_i;
                    if (issue_rd_i != '0) begin
                        pend_d[issue_rd_i] = 1'b1;
                    end
                end
            end
            LU_BUSY: begin
                // DONE is entered on the edge where the counter reaches zero,
                // giving LU_LAT-1 BUSY cycles plus one DONE cycle after issue.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (cnt_q <= LU_CNT_W'(1)) begin
                    state_d = LU_DONE;
                end
            end
            LU_DONE: begin
                pend_d[tag_q] = 1'b0;
                state_d       = LU_IDLE;
            end
            default: begin
                state_d = LU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= LU_IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            pend_q  <= pend_d;
        end
    end

    assign busy_o     = (state_q != LU_IDLE);
    assign pending_o  = pend_q;
    assign wb_valid_o = (state_q == LU_DONE);
    assign wb_rd_o    = tag_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Pipeline hazard unit: load-use, scoreboard RAW/WAW and structural stall
//   detection, branch flush, EX operand forwarding selects, long-latency unit
//   start, and a saturating stall-cycle counter.
//
// Ports
//   clk, reset_n                    clock, synchronous active-low reset
//   d_rs1/d_rs2/d_rd, d_use_*,      ID-stage fields and usage flags
//   d_reg_we, d_long_issue
//   e_b_taken, e_rs1, e_rs2         EX-stage branch and source fields
//   m_rd, m_reg_we, m_is_load       DM-stage destination info
//   w_rd, w_reg_we                  WB-stage destination info
//   forward_rrd1/2                  forwarding selects (NO/DM/WB)
//   stall_f, stall_if_id,           pipeline stall/flush controls
//   flush_if_id, flush_id_ex
//   lu_start, lu_wb_valid, lu_wb_rd long unit start and result strobe
//   pending                         scoreboard vector
//   stall_cycles                    saturating stall counter
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_COUNT  = 32,
    parameter int REG_ADDR_W = $clog2(REG_COUNT),
    parameter int LONG_LAT   = 4,
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] d_rs1,
    input  logic [REG_ADDR_W-1:0] d_rs2,
    input  logic [REG_ADDR_W-1:0] d_rd,
    input  logic                  d_use_rs1,
    input  logic                  d_use_rs2,
    input  logic                  d_reg_we,
    input  logic                  d_long_issue,
    input  logic                  e_b_taken,
    input  logic [REG_ADDR_W-1:0] e_rs1,
    input  logic [REG_ADDR_W-1:0] e_rs2,
    input  logic [REG_ADDR_W-1:0] m_rd,
    input  logic                  m_reg_we,
    input  logic                  m_is_load,
    input  logic [REG_ADDR_W-1:0] w_rd,
    input  logic                  w_reg_we,
    output fwd_sel_e              forward_rrd1,
    output fwd_sel_e              forward_rrd2,
    output logic                  stall_f,
    output logic                  stall_if_id,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  lu_start,
    output logic                  lu_wb_valid,
    output logic [REG_ADDR_W-1:0] lu_wb_rd,
    output logic [REG_COUNT-1:0]  pending,
    output logic [PERF_W-1:0]     stall_cycles
);

    logic              src1_hit, src2_hit;
    logic              load_use, raw, waw, struct_haz, stall, issue;
    logic              lu_busy;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

    function automatic fwd_sel_e fwd_select(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] mrd,
        input logic                  mwe,
        input logic [REG_ADDR_W-1:0] wrd,
        input logic                  wwe
    );
        fwd_sel_e sel;
        sel = FWD_NO;
        if (rs != '0 && mwe && mrd == rs) begin
            sel = FWD_DM;
        end else if (rs != '0 && wwe && wrd == rs) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    assign src1_hit = d_use_rs1 && (d_rs1 != '0);
    assign src2_hit = d_use_rs2 && (d_rs2 != '0);

    assign load_use = m_is_load && m_reg_we && (m_rd != '0) &&
                      ((src1_hit && d_rs1 == m_rd) || (src2_hit && d_rs2 == m_rd));
    assign raw        = (src1_hit && pending[d_rs1]) || (src2_hit && pending[d_rs2]);
    assign waw        = d_reg_we && (d_rd != '0) && pending[d_rd];
    assign struct_haz = d_long_issue && lu_busy;
    assign stall      = load_use || raw || waw || struct_haz;

    assign stall_f     = stall;
    assign stall_if_id = stall;
    assign flush_if_id = e_b_taken;
    assign flush_id_ex = e_b_taken || stall;

    // Reset gates the start so nothing launches while reset is held.
    assign issue    = reset_n && d_long_issue && !stall && !e_b_taken;
    assign lu_start = issue;

    assign forward_rrd1 = fwd_select(e_rs1, m_rd, m_reg_we, w_rd, w_reg_we);
    assign forward_rrd2 = fwd_select(e_rs2, m_rd, m_reg_we, w_rd, w_reg_we);

    lu_tracker #(
        .REG_COUNT  (REG_COUNT),
        .REG_ADDR_W (REG_ADDR_W),
        .LONG_LAT   (LONG_LAT)
    ) u_lu_tracker (
        .clk        (clk),
        .reset_n    (reset_n),
        .issue_i    (issue),
        .issue_rd_i (d_rd),
        .busy_o     (lu_busy),
        .pending_o  (pending),
        .wb_valid_o (lu_wb_valid),
        .wb_rd_o    (lu_wb_rd)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule
